// File: rtl/subtractor_serial.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - borrow_in, CHUNK bits per clock, LSB first.
// Optional signed-overflow flag and port enabled by defining SUB_OVERFLOW_EN.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | resolving one chunk per cycle, borrow carried in borrow_reg
// DONE  | out_valid=1, result held until out_ready
module subtractor_serial #(
  parameter int WIDTH = 6,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_param
    $error("subtractor_serial: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic              borrow_reg;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  a_chunk, b_chunk, d_chunk;
  logic              bw_chunk;
  logic              last_chunk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    last_chunk = (idx == LAST);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One chunk of the borrow chain; the extra top bit is the borrow out of the chunk.
  always_comb begin
    a_chunk = a_reg[int'(idx)*CHUNK +: CHUNK];
    b_chunk = b_reg[int'(idx)*CHUNK +: CHUNK];
    {bw_chunk, d_chunk} = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      idx        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= borrow_in;
            idx        <= '0;
          end
        end
        RUN: begin
          diff[int'(idx)*CHUNK +: CHUNK] <= d_chunk;
          borrow_reg <= bw_chunk;
          if (last_chunk) begin
            idx        <= '0;
            borrow_out <= bw_chunk;
`ifdef SUB_OVERFLOW_EN
            // d_chunk MSB is the final diff sign bit.
            overflow   <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (d_chunk[CHUNK-1] ^ a_reg[WIDTH-1]);
`endif
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial (WIDTH=6, CHUNK=3); overflow checks build with SUB_OVERFLOW_EN.
module tb_subtractor_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] a, b;
  logic       borrow_in;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] diff;
  logic       borrow_out;
`ifdef SUB_OVERFLOW_EN
  logic       overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  subtractor_serial #(.WIDTH(6), .CHUNK(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents operands, checks acceptance and latency, checks the result; leaves the block in DONE.
  // Latency is counted with the accepting edge as edge 1, so out_valid is expected after edge 3.
  task automatic start_op(input string tag, input logic [5:0] av, input logic [5:0] bv,
                          input logic bin, input logic [5:0] exp_diff, input logic exp_bw);
    int edges;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    borrow_in = bin;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = ~av;
    b         = ~bv;
    borrow_in = ~bin;
    chk({tag, "_in_ready_busy"}, in_ready, 0);
    edges = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (out_valid) break;
    end
    chk({tag, "_latency"}, edges, 3);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_diff"}, diff, exp_diff);
    chk({tag, "_borrow_out"}, borrow_out, exp_bw);
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    logic [5:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow_out", borrow_out, 0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_overflow", overflow, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    start_op("basic", 6'd5, 6'd3, 1'b0, 6'd2, 1'b0);
`ifdef SUB_OVERFLOW_EN
    chk("basic_overflow", overflow, 0);
`endif
    finish_op("basic");

    start_op("under0", 6'd0, 6'd1, 1'b0, 6'd63, 1'b1);
    finish_op("under0");

    start_op("under63", 6'd63, 6'd63, 1'b1, 6'd63, 1'b1);
    finish_op("under63");

    start_op("chunkbw", 6'd8, 6'd1, 1'b0, 6'd7, 1'b0);
    finish_op("chunkbw");

    start_op("mixed", 6'd45, 6'd18, 1'b1, 6'd26, 1'b0);
    finish_op("mixed");

    start_op("neg", 6'd10, 6'd20, 1'b0, 6'd54, 1'b1);
    finish_op("neg");

`ifdef SUB_OVERFLOW_EN
    start_op("ovf", 6'd32, 6'd1, 1'b0, 6'd31, 1'b0);
    chk("ovf_overflow", overflow, 1);
    finish_op("ovf");
`endif

    // Backpressure: result must hold and a new request must not be taken while in DONE.
    start_op("bp", 6'd20, 6'd7, 1'b0, 6'd13, 1'b1 ^ 1'b1);
    held = diff;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 6'd1;
    b        = 6'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid_hold", out_valid, 1);
      chk("bp_diff_hold", diff, held);
      chk("bp_in_ready_low", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_op("bp");
    chk("bp_diff_after", diff, 13);

    // Reset after the first RUN cycle discards the operation.
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 6'd5;
    b         = 6'd3;
    borrow_in = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_diff", diff, 0);
    chk("mrst_borrow_out", borrow_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("mrst_no_out_valid", out_valid, 0);
    end

    start_op("post_rst", 6'd33, 6'd40, 1'b1, 6'd56, 1'b1);
    finish_op("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
